// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg : shared states, opcodes and alu_op codes of the MIPS control
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_ctrl_pkg;

  localparam int OPC_W = 6;
  localparam int ALU_W = 3;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_R_EXEC    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_I_EXEC    = 4'd11,
    ST_I_WB      = 4'd12,
    ST_TRAP      = 4'd15
  } state_t;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'b001010;

  localparam logic [ALU_W-1:0] ALUOP_ADD   = 3'b000;
  localparam logic [ALU_W-1:0] ALUOP_SUB   = 3'b001;
  localparam logic [ALU_W-1:0] ALUOP_FUNCT = 3'b010;
  localparam logic [ALU_W-1:0] ALUOP_OR    = 3'b011;
  localparam logic [ALU_W-1:0] ALUOP_SLT   = 3'b100;
  localparam logic [ALU_W-1:0] ALUOP_AND   = 3'b101;

  typedef struct packed {
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_source;
    logic [ALU_W-1:0] alu_op;
    logic             illegal_op;
  } ctrl_t;

  function automatic logic [ALU_W-1:0] imm_alu_op(input logic [OPC_W-1:0] op);
    case (op)
      OP_ANDI: imm_alu_op = ALUOP_AND;
      OP_ORI:  imm_alu_op = ALUOP_OR;
      OP_SLTI: imm_alu_op = ALUOP_SLT;
      default: imm_alu_op = ALUOP_ADD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_ctrl_out_decode.sv
// ---------------------------------------------------------------------------
// mips_ctrl_out_decode : state -> datapath control decoder (Moore, plus the
// mem_ready-qualified FETCH loads)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_t           state,
  input  logic             mem_ready,
  input  logic [OPC_W-1:0] op_latched,
  output ctrl_t            ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = 2'b11;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      ST_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        // PC load is gated by the ALU zero flag inside the datapath
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
      ST_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = imm_alu_op(op_latched);
      end
      ST_I_WB: begin
        ctrl.reg_write = 1'b1;
      end
      ST_TRAP: begin
        ctrl.illegal_op = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_multiciclo_control_fsm.sv
// ---------------------------------------------------------------------------
// mips_multiciclo_control_fsm : multicycle MIPS main control FSM
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_multiciclo_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_source,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [3:0]          state_o,
  output logic                illegal_op
);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  ctrl_t               ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Opcode captured on DECODE exit keeps later-state decode stable
  always_comb begin
    op_d = op_q;
    if (state_q == ST_DECODE) op_d = opcode;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = ST_FETCH;
      ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:                          state_d = ST_R_EXEC;
          OP_LW, OP_SW:                      state_d = ST_MEM_ADDR;
          OP_BEQ:                            state_d = ST_BRANCH;
          OP_J:                              state_d = ST_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = ST_I_EXEC;
          default:                           state_d = ST_TRAP;
        endcase
      end
      ST_MEM_ADDR:  state_d = (op_q == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB:    state_d = ST_FETCH;
      ST_MEM_WRITE: if (mem_ready) state_d = ST_FETCH;
      ST_R_EXEC:    state_d = ST_R_WB;
      ST_R_WB:      state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      ST_JUMP:      state_d = ST_FETCH;
      ST_I_EXEC:    state_d = ST_I_WB;
      ST_I_WB:      state_d = ST_FETCH;
      ST_TRAP:      state_d = ST_TRAP;
      default:      state_d = ST_TRAP;
    endcase
  end

  mips_ctrl_out_decode u_out_decode (
    .state      (state_q),
    .mem_ready  (mem_ready),
    .op_latched (op_q),
    .ctrl       (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign pc_source     = ctrl.pc_source;
  assign alu_op        = ctrl.alu_op;
  assign illegal_op    = ctrl.illegal_op;
  assign state_o       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_multiciclo_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mips_multiciclo_control_fsm : scoreboard bench for the MIPS control FSM
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mips_multiciclo_control_fsm;

  localparam logic [5:0] C_RT   = 6'b000000;
  localparam logic [5:0] C_LW   = 6'b100011;
  localparam logic [5:0] C_SW   = 6'b101011;
  localparam logic [5:0] C_BEQ  = 6'b000100;
  localparam logic [5:0] C_J    = 6'b000010;
  localparam logic [5:0] C_ADDI = 6'b001000;
  localparam logic [5:0] C_ANDI = 6'b001100;
  localparam logic [5:0] C_ORI  = 6'b001101;
  localparam logic [5:0] C_SLTI = 6'b001010;
  localparam logic [5:0] C_BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state_o;

  mips_multiciclo_control_fsm #(.OPCODE_W(6), .ALUOP_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .state_o(state_o), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  wire [21:0] dut_vec = {state_o, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                         ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                         alu_src_b, pc_source, alu_op, illegal_op};

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        mr;
    logic        zf;
    logic [3:0]  st;
    logic [21:0] exp;
  } step_t;

  step_t q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_cycle  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, n_cycle, got, exp);
    end
  endtask

  // Reference output table written from the state descriptions
  function automatic logic [21:0] exp_vec(input logic [3:0] st, input logic mr, input logic [5:0] op);
    logic pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, ill;
    logic [1:0] sb, ps;
    logic [2:0] aop;
    {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, ill} = '0;
    sb = 2'b00; ps = 2'b00; aop = 3'b000;
    case (st)
      4'd1:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      4'd2:  sb = 2'b11;
      4'd3:  begin sa = 1; sb = 2'b10; end
      4'd4:  begin mrd = 1; iord = 1; end
      4'd5:  begin rw = 1; m2r = 1; end
      4'd6:  begin mwr = 1; iord = 1; end
      4'd7:  begin sa = 1; aop = 3'b010; end
      4'd8:  begin rw = 1; rdst = 1; end
      4'd9:  begin sa = 1; aop = 3'b001; pwc = 1; ps = 2'b01; end
      4'd10: begin pw = 1; ps = 2'b10; end
      4'd11: begin
        sa = 1; sb = 2'b10;
        case (op)
          C_ANDI:  aop = 3'b101;
          C_ORI:   aop = 3'b011;
          C_SLTI:  aop = 3'b100;
          default: aop = 3'b000;
        endcase
      end
      4'd12: rw = 1;
      4'd15: ill = 1;
      default: ;
    endcase
    return {st, pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ps, aop, ill};
  endfunction

  task automatic push_step(input logic rst_n, input logic [5:0] op, input logic mr,
                           input logic zf, input logic [3:0] st);
    step_t s;
    s.rst_n = rst_n; s.op = op; s.mr = mr; s.zf = zf; s.st = st;
    s.exp   = rst_n ? exp_vec(st, mr, op) : 22'd0;
    q.push_back(s);
  endtask

  // Instruction with zero-wait memory: FETCH, DECODE, then the listed states
  task automatic push_instr(input logic [5:0] op, input logic zf);
    push_step(1, op, 1, zf, 4'd1);
    push_step(1, op, 1, zf, 4'd2);
    case (op)
      C_RT:  begin push_step(1, op, 1, zf, 4'd7); push_step(1, op, 1, zf, 4'd8); end
      C_LW:  begin push_step(1, op, 1, zf, 4'd3); push_step(1, op, 1, zf, 4'd4);
                   push_step(1, op, 1, zf, 4'd5); end
      C_SW:  begin push_step(1, op, 1, zf, 4'd3); push_step(1, op, 1, zf, 4'd6); end
      C_BEQ: push_step(1, op, 1, zf, 4'd9);
      C_J:   push_step(1, op, 1, zf, 4'd10);
      default: begin push_step(1, op, 1, zf, 4'd11); push_step(1, op, 1, zf, 4'd12); end
    endcase
  endtask

  task automatic drain();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      reset_n = s.rst_n; opcode = s.op; mem_ready = s.mr; zero = s.zf;
      #1;
      n_cycle++;
      check_eq($sformatf("state%0d_outputs", s.st), {10'd0, dut_vec}, {10'd0, s.exp});
      check_eq("write_exclusive", {31'd0, mem_write & reg_write}, 32'd0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs", {10'd0, dut_vec}, 32'd0);

    // Release, start a lw, then reset while it stalls in MEM_READ
    push_step(1, C_LW, 1, 0, 4'd0);
    push_step(1, C_LW, 1, 0, 4'd1);
    push_step(1, C_LW, 1, 0, 4'd2);
    push_step(1, C_LW, 1, 0, 4'd3);
    push_step(1, C_LW, 0, 0, 4'd4);
    push_step(1, C_LW, 0, 0, 4'd4);
    push_step(0, C_LW, 0, 0, 4'd0);
    push_step(0, C_LW, 1, 0, 4'd0);
    push_step(1, C_LW, 1, 0, 4'd0);
    drain();

    push_instr(C_RT, 0);
    // lw with three wait cycles in MEM_READ
    push_step(1, C_LW, 1, 0, 4'd1);
    push_step(1, C_LW, 1, 0, 4'd2);
    push_step(1, C_LW, 1, 0, 4'd3);
    for (int i = 0; i < 3; i++) push_step(1, C_LW, 0, 0, 4'd4);
    push_step(1, C_LW, 1, 0, 4'd4);
    push_step(1, C_LW, 1, 0, 4'd5);
    push_instr(C_LW, 0);
    push_instr(C_SW, 0);
    // fetch stall: no IR/PC load while memory is busy
    push_step(1, C_BEQ, 0, 1, 4'd1);
    push_instr(C_BEQ, 1);
    push_instr(C_BEQ, 0);
    push_instr(C_J, 0);
    push_instr(C_ORI, 0);
    push_instr(C_SLTI, 0);
    push_instr(C_ADDI, 0);
    push_instr(C_ANDI, 0);
    // sw with one wait cycle in MEM_WRITE
    push_step(1, C_SW, 1, 0, 4'd1);
    push_step(1, C_SW, 1, 0, 4'd2);
    push_step(1, C_SW, 1, 0, 4'd3);
    push_step(1, C_SW, 0, 0, 4'd6);
    push_step(1, C_SW, 1, 0, 4'd6);
    // illegal opcode traps and stays trapped
    push_step(1, C_BAD, 1, 0, 4'd1);
    push_step(1, C_BAD, 1, 0, 4'd2);
    for (int i = 0; i < 20; i++) push_step(1, C_BAD, (i % 2) == 0, 0, 4'd15);
    push_step(0, C_BAD, 1, 0, 4'd0);
    push_step(1, C_RT, 1, 0, 4'd0);
    push_instr(C_RT, 0);
    push_step(1, C_RT, 1, 0, 4'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
